// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame scheduler.
// Active/shadow frames are stored with the driver's bit numbering [193:2],
// so slot_lsb() returns the absolute LSB of a channel inside a chain word.
package led_pkg;

    localparam int GS_W         = 12;
    localparam int CH_PER_CHAIN = 16;
    localparam int N_CHAIN      = 4;
    localparam int FRAME_W      = GS_W * CH_PER_CHAIN;
    localparam int IDLE_TIMEOUT = 4096;
    localparam int TMR_W        = $clog2(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        PEND  = 2'd2,
        SWAP  = 2'd3
    } sched_state_t;

    // Channel n of a chain sits at [12n+13 : 12n+2].
    function automatic logic [7:0] slot_lsb(input logic [3:0] chan);
        return 8'(chan) * 8'(GS_W) + 8'd2;
    endfunction

endpackage

// File: rtl/led_rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant, pointer flips on
// every accepted beat. Grant is purely combinational from valid/pointer/en.
module led_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_en,
    output logic [1:0] o_grant
);

    logic r_ptr;

    // Grant: lone requester wins; on contention the pointer decides.
    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            if (i_valid == 2'b11) o_grant = r_ptr ? 2'b10 : 2'b01;
            else                  o_grant = i_valid;
        end
    end

    // Pointer toggles after each accepted beat; reset favours req 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_ptr <= 1'b0;
        else if (|o_grant) r_ptr <= ~r_ptr;
    end

endmodule

// File: rtl/led_frame_scheduler.sv
// TLC5940 frame scheduler: two requesters write 12-bit channels into a
// shadow frame; a "last" beat commits it and the driver's frame_sync copies
// it into the active frame, so the driver never sees a half-written frame.
// Optional build macro LED_SCHED_DIM_EN adds a dim[7:0] input and scales each
// stored value by (dim+1)/256 through one registered multiplier.
module led_frame_scheduler
    import led_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [3:0]   req_chain,
    input  logic [7:0]   req_chan,
    input  logic [23:0]  req_gs,
    input  logic [1:0]   req_last,
    input  logic         shadow_clr,
    input  logic         frame_sync,
`ifdef LED_SCHED_DIM_EN
    input  logic [7:0]   dim,
`endif
    output logic [193:2] data_register0,
    output logic [193:2] data_register1,
    output logic [193:2] data_register2,
    output logic [193:2] data_register3,
    output logic         commit_pending,
    output logic         swap_done,
    output logic         owner
);

    sched_state_t r_state, w_next;
    logic [TMR_W-1:0] r_idle_cnt;
    logic r_clr_def;
    logic r_owner;
    logic [N_CHAIN-1:0][FRAME_W+1:2] r_shadow;
    logic [N_CHAIN-1:0][FRAME_W+1:2] r_active;

    logic w_open, w_acc, w_sel, w_clr, w_wr, w_last;
    logic [1:0] w_grant, w_chain;
    logic [3:0] w_chan;
    logic [GS_W-1:0] w_gs;

    // Shadow write port (after optional scaling stage).
    logic w_sh_we;
    logic [1:0] w_sh_chain;
    logic [3:0] w_sh_chan;
    logic [GS_W-1:0] w_sh_gs;

    assign w_open = (r_state == IDLE) || (r_state == WRITE);

    led_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_valid(req_valid),
        .i_en   (w_open),
        .o_grant(w_grant)
    );

    assign req_ready = w_grant;
    assign w_acc     = |w_grant;
    assign w_sel     = w_grant[1];
    assign w_chain   = w_sel ? req_chain[3:2]  : req_chain[1:0];
    assign w_chan    = w_sel ? req_chan[7:4]   : req_chan[3:0];
    assign w_gs      = w_sel ? req_gs[23:12]   : req_gs[11:0];
    assign w_last    = w_sel ? req_last[1]     : req_last[0];

    // A clear (fresh or deferred from PEND/SWAP) only takes effect while the
    // frame is open; beats accepted in the clearing cycle are dropped.
    assign w_clr = w_open & (shadow_clr | r_clr_def);
    assign w_wr  = w_acc & ~w_clr;

`ifdef LED_SCHED_DIM_EN
    logic r_p_vld;
    logic [1:0] r_p_chain;
    logic [3:0] r_p_chan;
    logic [19:0] r_p_prod;
    logic [8:0] w_dim_p1;

    assign w_dim_p1 = {1'b0, dim} + 9'd1;

    // Scaling stage: register gs*(dim+1); 4095*256 fits in 20 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_vld   <= 1'b0;
            r_p_chain <= '0;
            r_p_chan  <= '0;
            r_p_prod  <= '0;
        end else begin
            r_p_vld   <= w_wr;
            r_p_chain <= w_chain;
            r_p_chan  <= w_chan;
            r_p_prod  <= 20'(w_gs) * 20'(w_dim_p1);
        end
    end

    assign w_sh_we    = r_p_vld;
    assign w_sh_chain = r_p_chain;
    assign w_sh_chan  = r_p_chan;
    assign w_sh_gs    = 12'(r_p_prod >> 8);
`else
    assign w_sh_we    = w_wr;
    assign w_sh_chain = w_chain;
    assign w_sh_chan  = w_chan;
    assign w_sh_gs    = w_gs;
`endif

    // Shadow frame: clear wins over any write landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_shadow <= '0;
        else if (w_clr)   r_shadow <= '0;
        else if (w_sh_we) r_shadow[w_sh_chain][slot_lsb(w_sh_chan) +: GS_W] <= w_sh_gs;
    end

    // Active frame only changes at the end of SWAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_active <= '0;
        else if (r_state == SWAP)  r_active <= r_shadow;
    end

    // Remember a clear requested while the frame is locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_clr_def <= 1'b0;
        else if (w_clr)                  r_clr_def <= 1'b0;
        else if (shadow_clr && !w_open)  r_clr_def <= 1'b1;
    end

    // Owner follows the most recently accepted beat, dropped or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_owner <= 1'b0;
        else if (w_acc) r_owner <= w_sel;
    end

    // Idle timer: counts quiet cycles spent in WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_idle_cnt <= '0;
        else if (r_state != WRITE || w_acc) r_idle_cnt <= '0;
        else                                r_idle_cnt <= r_idle_cnt + TMR_W'(1);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state: a kept "last" beat commits; frame_sync only acts in PEND.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_acc) w_next = (w_wr && w_last) ? PEND : WRITE;
            WRITE: begin
                if (w_wr && w_last)
                    w_next = PEND;
                else if (!w_acc && r_idle_cnt == TMR_W'(IDLE_TIMEOUT - 1))
                    w_next = IDLE;
            end
            PEND:  if (frame_sync) w_next = SWAP;
            SWAP:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign commit_pending = (r_state == PEND);
    assign swap_done      = (r_state == SWAP);
    assign owner          = r_owner;
    assign data_register0 = r_active[0];
    assign data_register1 = r_active[1];
    assign data_register2 = r_active[2];
    assign data_register3 = r_active[3];

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench for led_frame_scheduler: directed table rows with
// hand-written expectations plus a random phase, all checked against a
// frame-level reference model (shadow/active arrays, pending flags).
module tb_led_frame_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid, req_ready, req_last;
    logic [3:0]   req_chain;
    logic [7:0]   req_chan;
    logic [23:0]  req_gs;
    logic         shadow_clr, frame_sync;
    logic [193:2] data_register0, data_register1, data_register2, data_register3;
    logic         commit_pending, swap_done, owner;
`ifdef LED_SCHED_DIM_EN
    logic [7:0]   dim = 8'd255;
`endif

    led_frame_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_chain(req_chain), .req_chan(req_chan), .req_gs(req_gs),
        .req_last(req_last), .shadow_clr(shadow_clr), .frame_sync(frame_sync),
`ifdef LED_SCHED_DIM_EN
        .dim(dim),
`endif
        .data_register0(data_register0), .data_register1(data_register1),
        .data_register2(data_register2), .data_register3(data_register3),
        .commit_pending(commit_pending), .swap_done(swap_done), .owner(owner)
    );

    always #5 clk = ~clk;

    logic [191:0] dr [4];
    assign dr[0] = data_register0;
    assign dr[1] = data_register1;
    assign dr[2] = data_register2;
    assign dr[3] = data_register3;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [3:0]  chain;
        logic [7:0]  chan;
        logic [23:0] gs;
        logic [1:0]  last;
        logic        clr;
        logic        fs;
        bit          use_exp;
        logic [1:0]  e_ready;
        logic        e_pend;
        logic        e_swap;
        bit          chk_own;
        logic        e_own;
    } vec_t;

    vec_t tbl[$];

    // Reference model: frames as channel arrays, protocol as flags.
    logic [11:0] m_sh  [4][16];
    logic [11:0] m_act [4][16];
    bit m_pend, m_swap, m_clrdef, m_ptr, m_owner;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] scale(input logic [11:0] g);
`ifdef LED_SCHED_DIM_EN
        return 12'((32'(g) * (32'(dim) + 32'd1)) >> 8);
`else
        return g;
`endif
    endfunction

    function automatic vec_t mk(input logic [1:0] valid, input logic [3:0] chain,
                                input logic [7:0] chan, input logic [23:0] gs,
                                input logic [1:0] last, input logic clr, input logic fs,
                                input logic [1:0] e_ready, input logic e_pend, input logic e_swap);
        vec_t v;
        v.valid = valid; v.chain = chain; v.chan = chan; v.gs = gs; v.last = last;
        v.clr = clr; v.fs = fs; v.use_exp = 1'b1;
        v.e_ready = e_ready; v.e_pend = e_pend; v.e_swap = e_swap;
        v.chk_own = 1'b0; v.e_own = 1'b0;
        return v;
    endfunction

    function automatic vec_t idle_v(input logic e_pend, input logic e_swap);
        return mk(2'b00, 4'h0, 8'h00, 24'h0, 2'b00, 1'b0, 1'b0, 2'b00, e_pend, e_swap);
    endfunction

    function automatic vec_t fs_v(input logic e_pend);
        return mk(2'b00, 4'h0, 8'h00, 24'h0, 2'b00, 1'b0, 1'b1, 2'b00, e_pend, 1'b0);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++)
            for (int n = 0; n < 16; n++) begin
                m_sh[c][n] = '0; m_act[c][n] = '0;
            end
        m_pend = 0; m_swap = 0; m_clrdef = 0; m_ptr = 0; m_owner = 0;
    endtask

    // One clock: drive at negedge, check ready/flags, update model at
    // posedge, check frames/owner just after it.
    task automatic step(input vec_t v);
        logic [1:0] g;
        logic [191:0] e;
        bit en, clr_eff;
        int gi, ch, cn;
        req_valid = v.valid; req_chain = v.chain; req_chan = v.chan;
        req_gs = v.gs; req_last = v.last; shadow_clr = v.clr; frame_sync = v.fs;
        #1;
        en = !m_pend && !m_swap;
        g  = 2'b00;
        if (en) g = (v.valid == 2'b11) ? (m_ptr ? 2'b10 : 2'b01) : v.valid;
        chk("req_ready", 192'(req_ready), 192'(g));
        chk("commit_pending", 192'(commit_pending), 192'(m_pend));
        chk("swap_done", 192'(swap_done), 192'(m_swap));
        if (v.use_exp) begin
            chk("tbl_ready", 192'(req_ready), 192'(v.e_ready));
            chk("tbl_pend", 192'(commit_pending), 192'(v.e_pend));
            chk("tbl_swap", 192'(swap_done), 192'(v.e_swap));
        end
        @(posedge clk);
        clr_eff = en && (v.clr || m_clrdef);
        if (m_swap) begin
            m_act = m_sh; m_swap = 0;
        end else if (m_pend && v.fs) begin
            m_pend = 0; m_swap = 1;
        end
        if (v.clr && !en) m_clrdef = 1;
        if (g != 2'b00) begin
            gi = g[1] ? 1 : 0;
            m_owner = g[1];
            m_ptr = !m_ptr;
            if (!clr_eff) begin
                ch = int'(v.chain[gi*2 +: 2]);
                cn = int'(v.chan[gi*4 +: 4]);
                m_sh[ch][cn] = scale(v.gs[gi*12 +: 12]);
                if (v.last[gi]) m_pend = 1;
            end
        end
        if (clr_eff) begin
            for (int c = 0; c < 4; c++)
                for (int n = 0; n < 16; n++) m_sh[c][n] = '0;
            m_clrdef = 0;
        end
        #1;
        for (int c = 0; c < 4; c++) begin
            for (int n = 0; n < 16; n++) e[n*12 +: 12] = m_act[c][n];
            chk($sformatf("data_register%0d", c), dr[c], e);
        end
        chk("owner", 192'(owner), 192'(m_owner));
        if (v.chk_own) chk("tbl_owner", 192'(owner), 192'(v.e_own));
        @(negedge clk);
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        tbl.delete();
    endtask

    // Asynchronous reset: outputs must blank before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_chain = '0; req_chan = '0; req_gs = '0;
        req_last = '0; shadow_clr = 1'b0; frame_sync = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) chk($sformatf("rst_dr%0d", c), dr[c], 192'd0);
        chk("rst_ready", 192'(req_ready), 192'd0);
        chk("rst_pend", 192'(commit_pending), 192'd0);
        chk("rst_swap", 192'(swap_done), 192'd0);
        chk("rst_owner", 192'(owner), 192'd0);
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [191:0] e;
        vec_t v;
        rst_n = 1'b1;
        #2;
        do_reset();

        // Single committed write, swap ~50 cycles later.
        tbl.push_back(mk(2'b01, 4'h2, 8'h0F, 24'h000ABC, 2'b01, 0, 0, 2'b01, 0, 0));
        for (int i = 0; i < 48; i++) tbl.push_back(idle_v(1, 0));
        tbl.push_back(fs_v(1));
        tbl.push_back(idle_v(0, 1));
        tbl.push_back(idle_v(0, 0));
        run_tbl();
        chk("t2_dr2", dr[2], {12'hABC, 180'd0});
        chk("t2_dr0", dr[0], 192'd0);
        chk("t2_dr1", dr[1], 192'd0);
        chk("t2_dr3", dr[3], 192'd0);

        // Mid-frame reset blanks the active frame immediately.
        do_reset();

        // Both requesters valid: strict alternation 0,1,0,1...
        for (int k = 0; k < 16; k++) begin
            v = mk(2'b11, 4'b0100, {4'((k) / 2), 4'((k + 1) / 2)},
                   {12'h200 + 12'(k / 2), 12'h100 + 12'((k + 1) / 2)}, 2'b00, 0, 0,
                   (k % 2 == 0) ? 2'b01 : 2'b10, 0, 0);
            v.chk_own = 1'b1; v.e_own = (k % 2 == 1);
            tbl.push_back(v);
        end
        tbl.push_back(mk(2'b01, 4'h0, 8'h08, 24'h0001FF, 2'b01, 0, 0, 2'b01, 0, 0));
        tbl.push_back(idle_v(1, 0));
        tbl.push_back(fs_v(1));
        tbl.push_back(idle_v(0, 1));
        tbl.push_back(idle_v(0, 0));
        run_tbl();
        e = '0;
        for (int n = 0; n < 8; n++) e[n*12 +: 12] = 12'h100 + 12'(n);
        e[8*12 +: 12] = 12'h1FF;
        chk("t3_dr0", dr[0], e);
        e = '0;
        for (int n = 0; n < 8; n++) e[n*12 +: 12] = 12'h200 + 12'(n);
        chk("t3_dr1", dr[1], e);

        // last accepted together with frame_sync: swap waits for next sync.
        tbl.push_back(mk(2'b01, 4'h3, 8'h05, 24'h000555, 2'b01, 0, 1, 2'b01, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(2'b11, 4'h5, 8'h21, 24'h321123, 2'b11, 0, 0, 2'b00, 1, 0));
        tbl.push_back(mk(2'b11, 4'h5, 8'h21, 24'h321123, 2'b11, 0, 1, 2'b00, 1, 0));
        tbl.push_back(mk(2'b11, 4'h5, 8'h21, 24'h321123, 2'b11, 0, 0, 2'b00, 0, 1));
        tbl.push_back(idle_v(0, 0));
        run_tbl();
        e = '0; e[5*12 +: 12] = 12'h555;
        chk("t4_dr3", dr[3], e);

        // Clear then a last-only write to chain 0 ch 0.
        tbl.push_back(mk(2'b00, 4'h0, 8'h00, 24'h0, 2'b00, 1, 0, 2'b00, 0, 0));
        tbl.push_back(mk(2'b10, 4'h0, 8'h00, 24'h001000, 2'b10, 0, 0, 2'b10, 0, 0));
        tbl.push_back(idle_v(1, 0));
        tbl.push_back(fs_v(1));
        tbl.push_back(idle_v(0, 1));
        tbl.push_back(idle_v(0, 0));
        run_tbl();
        chk("t5_dr0", dr[0], 192'h1);
        chk("t5_dr1", dr[1], 192'd0);
        chk("t5_dr2", dr[2], 192'd0);
        chk("t5_dr3", dr[3], 192'd0);

        // Clear during PEND is deferred until IDLE.
        tbl.push_back(mk(2'b01, 4'b0001, 8'h03, 24'h000333, 2'b01, 0, 0, 2'b01, 0, 0));
        tbl.push_back(mk(2'b00, 4'h0, 8'h00, 24'h0, 2'b00, 1, 0, 2'b00, 1, 0));
        tbl.push_back(fs_v(1));
        tbl.push_back(idle_v(0, 1));
        tbl.push_back(idle_v(0, 0));
        tbl.push_back(mk(2'b01, 4'b0010, 8'h01, 24'h000777, 2'b01, 0, 0, 2'b01, 0, 0));
        tbl.push_back(idle_v(1, 0));
        tbl.push_back(fs_v(1));
        tbl.push_back(idle_v(0, 1));
        tbl.push_back(idle_v(0, 0));
        run_tbl();
        e = '0; e[1*12 +: 12] = 12'h777;
        chk("t6_dr2", dr[2], e);
        chk("t6_dr0", dr[0], 192'd0);
        chk("t6_dr1", dr[1], 192'd0);

`ifdef LED_SCHED_DIM_EN
        dim = 8'd127;
        tbl.push_back(mk(2'b01, 4'h0, 8'h02, 24'h000FFF, 2'b01, 0, 0, 2'b01, 0, 0));
        tbl.push_back(idle_v(1, 0));
        tbl.push_back(fs_v(1));
        tbl.push_back(idle_v(0, 1));
        tbl.push_back(idle_v(0, 0));
        run_tbl();
        chk("dim127", 192'(dr[0][2*12 +: 12]), 192'h7FF);
        dim = 8'd255;
        tbl.push_back(mk(2'b01, 4'h1, 8'h04, 24'h000123, 2'b01, 0, 0, 2'b01, 0, 0));
        tbl.push_back(idle_v(1, 0));
        tbl.push_back(fs_v(1));
        tbl.push_back(idle_v(0, 1));
        tbl.push_back(idle_v(0, 0));
        run_tbl();
        chk("dim255", 192'(dr[1][4*12 +: 12]), 192'h123);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            v.valid = 2'($urandom_range(0, 3));
            v.chain = 4'($urandom);
            v.chan  = 8'($urandom);
            v.gs    = 24'($urandom);
            v.last  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            v.clr   = ($urandom_range(0, 31) == 0);
            v.fs    = ($urandom_range(0, 5) == 0);
            v.use_exp = 1'b0; v.chk_own = 1'b0;
            v.e_ready = '0; v.e_pend = 1'b0; v.e_swap = 1'b0; v.e_own = 1'b0;
`ifdef LED_SCHED_DIM_EN
            dim = 8'($urandom);
`endif
            step(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
